// File: rtl/retire_rrf_pkg.sv
// Shared rename types: physical tag type, register counts and the RAT restore state encoding.
package rv32i_types;

  localparam int unsigned PHYS_REGS = 64;
  localparam int unsigned ARCH_REGS = 32;
  localparam int unsigned PTAG_W    = 6;

  typedef logic [PTAG_W-1:0] ptag_t;

  typedef enum logic {
    RRF_IDLE    = 1'b0,
    RRF_RESTORE = 1'b1
  } rrf_state_t;

endpackage

// File: rtl/retire_rrf.sv
// Retirement register file: committed arch-to-phys map, freed-tag return, retired count
// and the one-cycle RAT restore pulse after a mispredict.
module retire_rrf #(
  parameter int unsigned PHYS_REGS = rv32i_types::PHYS_REGS,
  parameter int unsigned ARCH_REGS = rv32i_types::ARCH_REGS
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   commit_valid,
  input  logic [4:0]                             commit_rd,
  input  logic [5:0]                             commit_pd,
  input  logic                                   commit_regf_we,
  input  logic                                   flush,
  output logic                                   free_valid,
  output logic [5:0]                             free_preg,
  output logic                                   rat_restore,
  output rv32i_types::ptag_t [ARCH_REGS-1:0]     rrf_map,
  output logic [63:0]                            retired_count
);

  import rv32i_types::*;

  localparam int unsigned TAG_W = $clog2(PHYS_REGS);

  rrf_state_t       state;
  logic             arch_commit;
  logic             do_free;
  logic [TAG_W-1:0] old_tag;

  // Writes to x0 and non-writing commits never touch the map; rewriting the same tag frees nothing.
  always_comb begin
    arch_commit = 1'b0;
    old_tag     = '0;
    do_free     = 1'b0;
    arch_commit = commit_valid && commit_regf_we && (commit_rd != 5'd0);
    old_tag     = rrf_map[commit_rd];
    do_free     = arch_commit && (old_tag != commit_pd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ARCH_REGS); i++) begin
        rrf_map[i] <= ptag_t'(i);
      end
      free_valid    <= 1'b0;
      free_preg     <= '0;
      state         <= RRF_IDLE;
      rat_restore   <= 1'b0;
      retired_count <= '0;
    end else begin
      if (arch_commit) begin
        rrf_map[commit_rd] <= commit_pd;
      end
      free_valid <= do_free;
      if (do_free) begin
        free_preg <= old_tag;
      end
      if (commit_valid) begin
        retired_count <= retired_count + 64'd1;
      end
      // A flush while already restoring re-enters RESTORE so the pulse has no gap.
      case (state)
        RRF_IDLE: begin
          state       <= flush ? RRF_RESTORE : RRF_IDLE;
          rat_restore <= flush;
        end
        RRF_RESTORE: begin
          state       <= flush ? RRF_RESTORE : RRF_IDLE;
          rat_restore <= flush;
        end
        default: begin
          state       <= RRF_IDLE;
          rat_restore <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_retire_rrf.sv
// Self-checking bench for retire_rrf: directed scenarios plus randomized commits/flushes
// against an array-based reference model of the committed map.
module tb_retire_rrf;
  import rv32i_types::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  commit_valid;
  logic [4:0]            commit_rd;
  logic [5:0]            commit_pd;
  logic                  commit_regf_we;
  logic                  flush;
  logic                  free_valid;
  logic [5:0]            free_preg;
  logic                  rat_restore;
  ptag_t [31:0]          rrf_map;
  logic [63:0]           retired_count;

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model
  int              m_map [32];
  bit              m_free_v;
  int              m_free_p;
  bit              m_restore;
  longint unsigned m_cnt;

  retire_rrf dut (
    .clk           (clk),
    .rst           (rst),
    .commit_valid  (commit_valid),
    .commit_rd     (commit_rd),
    .commit_pd     (commit_pd),
    .commit_regf_we(commit_regf_we),
    .flush         (flush),
    .free_valid    (free_valid),
    .free_preg     (free_preg),
    .rat_restore   (rat_restore),
    .rrf_map       (rrf_map),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_map[i] = i;
    m_free_v  = 0;
    m_free_p  = 0;
    m_restore = 0;
    m_cnt     = 0;
  endtask

  // Drive one cycle of inputs, clock it, and advance the model by the same cycle.
  task automatic step(input bit v, input int rd, input int pd, input bit we, input bit fl, input bit r);
    @(negedge clk);
    rst            = r;
    commit_valid   = v;
    commit_rd      = 5'(rd);
    commit_pd      = 6'(pd);
    commit_regf_we = we;
    flush          = fl;
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      if (v && we && rd != 0) begin
        m_free_v = (m_map[rd] != pd);
        if (m_free_v) m_free_p = m_map[rd];
        m_map[rd] = pd;
      end else begin
        m_free_v = 0;
      end
      m_restore = fl;
      if (v) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    int bad;
    step(1, 4, 60, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1);
    idle();
    bad = 0;
    for (int i = 0; i < 32; i++) if (rrf_map[i] !== 6'(i)) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL reset_map: %0d entries differ, map[5]=%0d want 5", bad, rrf_map[5]);
    end
    tests_run++;
    if (retired_count !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_count: got %0d want 0", retired_count);
    end
    tests_run++;
    if (free_valid !== 1'b0 || rat_restore !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: free_valid=%b rat_restore=%b want 0 0", free_valid, rat_restore);
    end
  endtask

  task automatic test_commit_basic();
    step(1, 5, 40, 1, 0, 0);
    tests_run++;
    if (rrf_map[5] !== 6'd40 || free_valid !== 1'b1 || free_preg !== 6'd5 || retired_count !== 64'd1) begin
      tests_failed++;
      $display("FAIL commit_basic: map5=%0d fv=%b fp=%0d cnt=%0d want 40 1 5 1",
               rrf_map[5], free_valid, free_preg, retired_count);
    end
    idle();
    tests_run++;
    if (free_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL free_one_cycle: free_valid=%b want 0", free_valid);
    end
  endtask

  task automatic test_x0_nowrite();
    longint unsigned c0;
    c0 = retired_count;
    step(1, 0, 33, 1, 0, 0);
    tests_run++;
    if (free_valid !== 1'b0 || rrf_map[0] !== 6'd0) begin
      tests_failed++;
      $display("FAIL x0_commit: fv=%b map0=%0d want 0 0", free_valid, rrf_map[0]);
    end
    step(1, 7, 41, 0, 0, 0);
    tests_run++;
    if (free_valid !== 1'b0 || rrf_map[7] !== 6'd7) begin
      tests_failed++;
      $display("FAIL nowrite_commit: fv=%b map7=%0d want 0 7", free_valid, rrf_map[7]);
    end
    tests_run++;
    if (retired_count !== c0 + 2) begin
      tests_failed++;
      $display("FAIL nonarch_count: got %0d want %0d", retired_count, c0 + 2);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 3, 50, 1, 0, 0);
    tests_run++;
    if (free_valid !== 1'b1 || free_preg !== 6'd3) begin
      tests_failed++;
      $display("FAIL b2b_first: fv=%b fp=%0d want 1 3", free_valid, free_preg);
    end
    step(1, 3, 51, 1, 0, 0);
    tests_run++;
    if (free_valid !== 1'b1 || free_preg !== 6'd50 || rrf_map[3] !== 6'd51) begin
      tests_failed++;
      $display("FAIL b2b_second: fv=%b fp=%0d map3=%0d want 1 50 51", free_valid, free_preg, rrf_map[3]);
    end
    step(1, 3, 51, 1, 0, 0);
    tests_run++;
    if (free_valid !== 1'b0 || rrf_map[3] !== 6'd51) begin
      tests_failed++;
      $display("FAIL no_double_free: fv=%b map3=%0d want 0 51", free_valid, rrf_map[3]);
    end
  endtask

  task automatic test_flush();
    step(1, 9, 45, 1, 1, 0);
    tests_run++;
    if (rat_restore !== 1'b1 || rrf_map[9] !== 6'd45) begin
      tests_failed++;
      $display("FAIL flush_snapshot: rr=%b map9=%0d want 1 45", rat_restore, rrf_map[9]);
    end
    idle();
    tests_run++;
    if (rat_restore !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_pulse: rr=%b want 0", rat_restore);
    end
    step(0, 0, 0, 0, 1, 0);
    step(1, 10, 46, 1, 1, 0);
    tests_run++;
    if (rat_restore !== 1'b1 || rrf_map[10] !== 6'd46) begin
      tests_failed++;
      $display("FAIL flush_refire: rr=%b map10=%0d want 1 46", rat_restore, rrf_map[10]);
    end
    idle();
    tests_run++;
    if (rat_restore !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_end: rr=%b want 0", rat_restore);
    end
  endtask

  task automatic test_reset_drop();
    step(1, 12, 20, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    tests_run++;
    if (free_valid !== 1'b0 || rrf_map[12] !== 6'd12) begin
      tests_failed++;
      $display("FAIL reset_drop_same: fv=%b map12=%0d want 0 12", free_valid, rrf_map[12]);
    end
    step(1, 12, 20, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    tests_run++;
    if (free_valid !== 1'b0 || rrf_map[12] !== 6'd12 || retired_count !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_drop_after: fv=%b map12=%0d cnt=%0d want 0 12 0",
               free_valid, rrf_map[12], retired_count);
    end
  endtask

  task automatic test_random();
    int rd, pd, bad;
    for (int n = 0; n < 400; n++) begin
      rd = int'($urandom_range(0, 31));
      pd = ($urandom_range(0, 3) == 0) ? m_map[rd] : int'($urandom_range(0, 63));
      step(bit'($urandom_range(0, 3) != 0), rd, pd, bit'($urandom_range(0, 3) != 0),
           bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 99) == 0));
      bad = 0;
      for (int i = 0; i < 32; i++) if (rrf_map[i] !== 6'(m_map[i])) bad++;
      tests_run++;
      if (bad != 0 || free_valid !== m_free_v || rat_restore !== m_restore || retired_count !== m_cnt ||
          (m_free_v && free_preg !== 6'(m_free_p))) begin
        tests_failed++;
        $display("FAIL random_%0d: mapdiff=%0d fv=%b/%b fp=%0d/%0d rr=%b/%b cnt=%0d/%0d (got/want)",
                 n, bad, free_valid, m_free_v, free_preg, m_free_p, rat_restore, m_restore,
                 retired_count, m_cnt);
      end
    end
  endtask

  initial begin
    rst = 1'b1; commit_valid = 1'b0; commit_rd = '0; commit_pd = '0;
    commit_regf_we = 1'b0; flush = 1'b0;
    model_reset();
    test_reset();
    test_commit_basic();
    test_x0_nowrite();
    test_back_to_back();
    test_flush();
    test_reset_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
